// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED text renderer: screen/glyph geometry,
// colour width, font ROM address layout, the renderer FSM state type and a
// helper that builds a font ROM address from a character code and glyph row.
// -----------------------------------------------------------------------------
package oled_pkg;

  // Screen and glyph geometry (pixels)
  localparam int OLED_NUM_COL        = 96;
  localparam int OLED_NUM_ROW        = 64;
  localparam int OLED_ASCII_COL_SIZE = 8;
  localparam int OLED_ASCII_ROW_SIZE = 8;

  // Pixel colour width
  localparam int OLED_N_COLOR_BITS   = 8;

  // Font ROM address = {character code, glyph row}
  localparam int OLED_CHAR_BITS      = 8;
  localparam int OLED_GLYPH_ROW_BITS = 3;
  localparam int OLED_FONT_ADDR_W    = OLED_CHAR_BITS + OLED_GLYPH_ROW_BITS;

  // One glyph row as returned by the font ROM (bit 7 = leftmost pixel)
  localparam int OLED_GLYPH_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } oled_state_e;

  // Character codes go to the ROM untouched; no printable-range filtering.
  function automatic logic [OLED_FONT_ADDR_W-1:0] font_addr_f(
    input logic [OLED_CHAR_BITS-1:0]      ch,
    input logic [OLED_GLYPH_ROW_BITS-1:0] glyph_row
  );
    return {ch, glyph_row};
  endfunction

endpackage

// File: rtl/oled_glyph_shift.sv
// -----------------------------------------------------------------------------
// oled_glyph_shift
// Holds one glyph row fetched from the font ROM and presents its leftmost
// pixel on o_msb. Each accepted pixel shifts the row left by one so the next
// pixel to the right becomes the MSB.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset, clears the row
//   i_load   : capture i_data (takes priority over i_shift)
//   i_data   : glyph row from the font ROM, bit 7 = leftmost pixel
//   i_shift  : advance one pixel (pixel handshake)
//   o_msb    : current pixel bit (1 = text colour, 0 = background)
// -----------------------------------------------------------------------------
module oled_glyph_shift
  import oled_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [OLED_GLYPH_W-1:0] i_data,
  input  logic                    i_shift,
  output logic                    o_msb
);

  logic [OLED_GLYPH_W-1:0] glyph_q;
  logic [OLED_GLYPH_W-1:0] glyph_d;

  always_comb begin
    glyph_d = glyph_q;
    if (i_load) begin
      glyph_d = i_data;
    end else if (i_shift) begin
      glyph_d = {glyph_q[OLED_GLYPH_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      glyph_q <= '0;
    end else begin
      glyph_q <= glyph_d;
    end
  end

  assign o_msb = glyph_q[OLED_GLYPH_W-1];

endmodule

// File: rtl/oled_text_render.sv
// -----------------------------------------------------------------------------
// oled_text_render
// Renders a full screen of 8x8 character cells into a raster pixel stream.
// On a frame request the text buffer and both colours are snapshotted, then
// for every 8-pixel glyph row the block fetches the glyph row from an
// external font ROM (1-cycle latency), loads it into a shift register and
// streams 8 pixels over a valid/ready handshake. Pixels come out row-major,
// x 0..NUM_COL-1 within y 0..NUM_ROW-1.
//
// Ports
//   i_clk              : clock, rising edge
//   i_rst_n            : synchronous active-low reset (aborts a frame)
//   i_frame_req        : start-of-frame request, honoured only in IDLE
//   i_ASCII            : screen text, char k at bits [8*(NCHARS-k)-1 -: 8]
//   i_BACKGROUND_COLOR : colour for glyph bit 0
//   i_TEXT_COLOR       : colour for glyph bit 1
//   o_font_addr        : {char, glyph_row} to the font ROM
//   i_font_data        : glyph row, valid one cycle after o_font_addr
//   o_pix_data         : pixel colour
//   o_pix_valid        : o_pix_data valid
//   i_pix_ready        : downstream accepts the pixel
//   o_busy             : frame in progress
//   o_frame_done       : one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module oled_text_render
  import oled_pkg::*;
#(
  parameter int NUM_COL        = OLED_NUM_COL,
  parameter int NUM_ROW        = OLED_NUM_ROW,
  parameter int ASCII_COL_SIZE = OLED_ASCII_COL_SIZE,
  parameter int ASCII_ROW_SIZE = OLED_ASCII_ROW_SIZE,
  parameter int N_COLOR_BITS   = OLED_N_COLOR_BITS
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_frame_req,
  input  logic [(NUM_COL/ASCII_COL_SIZE)*(NUM_ROW/ASCII_ROW_SIZE)*8-1:0] i_ASCII,
  input  logic [N_COLOR_BITS-1:0]     i_BACKGROUND_COLOR,
  input  logic [N_COLOR_BITS-1:0]     i_TEXT_COLOR,
  output logic [OLED_FONT_ADDR_W-1:0] o_font_addr,
  input  logic [OLED_GLYPH_W-1:0]     i_font_data,
  output logic [N_COLOR_BITS-1:0]     o_pix_data,
  output logic                        o_pix_valid,
  input  logic                        i_pix_ready,
  output logic                        o_busy,
  output logic                        o_frame_done
);

  localparam int NUM_ASCII_COL = NUM_COL / ASCII_COL_SIZE;
  localparam int NUM_ASCII_ROW = NUM_ROW / ASCII_ROW_SIZE;
  localparam int NUM_CHARS     = NUM_ASCII_COL * NUM_ASCII_ROW;
  localparam int X_W           = $clog2(NUM_COL);
  localparam int Y_W           = $clog2(NUM_ROW);
  localparam int GX_W          = $clog2(ASCII_COL_SIZE);
  localparam int GY_W          = $clog2(ASCII_ROW_SIZE);
  localparam int CIDX_W        = $clog2(NUM_CHARS);

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  oled_state_e state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Snapshot of the text buffer and colours taken at frame start
  logic [OLED_CHAR_BITS-1:0] ascii_in [NUM_CHARS];
  logic [OLED_CHAR_BITS-1:0] ascii_q  [NUM_CHARS];
  logic [N_COLOR_BITS-1:0]   bg_q;
  logic [N_COLOR_BITS-1:0]   text_q;

  logic snap_load;
  logic glyph_load;
  logic handshake;
  logic glyph_end;
  logic last_x;
  logic last_y;
  logic glyph_msb;

  // Unpack the flat text bus so char 0 (top-left) sits in the top byte.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHARS; gi++) begin : g_unpack
      assign ascii_in[gi] = i_ASCII[8*(NUM_CHARS-gi)-1 -: 8];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        ascii_q[i] <= '0;
      end
      bg_q   <= '0;
      text_q <= '0;
    end else if (snap_load) begin
      ascii_q <= ascii_in;
      bg_q    <= i_BACKGROUND_COLOR;
      text_q  <= i_TEXT_COLOR;
    end
  end

  // ---------------------------------------------------------------------------
  // Character lookup: the cell under the current pixel
  // ---------------------------------------------------------------------------
  logic [X_W-GX_W-1:0]       char_col;
  logic [Y_W-GY_W-1:0]       char_row;
  logic [CIDX_W-1:0]         char_idx;
  logic [OLED_CHAR_BITS-1:0] cur_char;

  assign char_col = x_q[X_W-1:GX_W];
  assign char_row = y_q[Y_W-1:GY_W];
  assign char_idx = CIDX_W'(char_row) * CIDX_W'(NUM_ASCII_COL) + CIDX_W'(char_col);
  assign cur_char = ascii_q[char_idx];

  // Counters hold through FETCH and LOAD, so the address is stable for the
  // whole ROM access even though it is derived combinationally.
  assign o_font_addr = font_addr_f(cur_char, y_q[OLED_GLYPH_ROW_BITS-1:0]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign handshake = (state_q == ST_STREAM) && i_pix_ready;
  assign glyph_end = (x_q[GX_W-1:0] == GX_W'(ASCII_COL_SIZE - 1));
  assign last_x    = (x_q == X_W'(NUM_COL - 1));
  assign last_y    = (y_q == Y_W'(NUM_ROW - 1));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    snap_load  = 1'b0;
    glyph_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_frame_req) begin
          snap_load = 1'b1;
          x_d       = '0;
          y_d       = '0;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        glyph_load = 1'b1;
        state_d    = ST_STREAM;
      end

      ST_STREAM: begin
        if (handshake) begin
          if (last_x) begin
            x_d = '0;
            y_d = last_y ? '0 : y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
          // A glyph row ends every 8 accepted pixels; the very last one of
          // the screen ends the frame instead of fetching again.
          if (glyph_end) begin
            state_d = (last_x && last_y) ? ST_DONE : ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Glyph row shift register
  // ---------------------------------------------------------------------------
  oled_glyph_shift u_glyph_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (glyph_load),
    .i_data  (i_font_data),
    .i_shift (handshake),
    .o_msb   (glyph_msb)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_pix_valid  = (state_q == ST_STREAM);
  assign o_pix_data   = o_pix_valid ? (glyph_msb ? text_q : bg_q) : '0;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_oled_text_render.sv
// -----------------------------------------------------------------------------
// tb_oled_text_render
// Self-checking bench for oled_text_render. A font ROM model with one cycle
// read latency is attached to the DUT. The expected pixel stream of each
// frame is computed from the text/colour snapshot and ROM contents with
// plain screen arithmetic, and every cycle where o_pix_valid is high the
// DUT pixel is compared with the expected pixel at the current raster index.
// -----------------------------------------------------------------------------
module tb_oled_text_render;

  localparam int NCH  = 96;
  localparam int NPIX = 96 * 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [767:0] ascii;
  logic [7:0]   bg_c;
  logic [7:0]   fg_c;
  logic [10:0]  font_addr;
  logic [7:0]   font_data;
  logic [7:0]   pix;
  logic         valid;
  logic         ready;
  logic         busy;
  logic         done;

  logic [7:0] rom     [2048];
  logic [7:0] txt     [NCH];
  logic [7:0] exp_pix [NPIX];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Font ROM: registered read, data valid one cycle after the address.
  always @(posedge clk) font_data <= rom[font_addr];

  oled_text_render dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_frame_req        (req),
    .i_ASCII            (ascii),
    .i_BACKGROUND_COLOR (bg_c),
    .i_TEXT_COLOR       (fg_c),
    .o_font_addr        (font_addr),
    .i_font_data        (font_data),
    .o_pix_data         (pix),
    .o_pix_valid        (valid),
    .i_pix_ready        (ready),
    .o_busy             (busy),
    .o_frame_done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic pack_text();
    for (int k = 0; k < NCH; k++) ascii[8*(NCH-k)-1 -: 8] = txt[k];
  endtask

  task automatic random_text();
    for (int k = 0; k < NCH; k++) txt[k] = 8'($urandom);
    pack_text();
  endtask

  // Reference: pixel (x,y) lies in cell (x/8, y/8); its glyph row is
  // rom[char*8 + y%8]; the pixel bit counts from bit 7 at the cell's left.
  task automatic build_model(input logic [7:0] bgv, input logic [7:0] fgv);
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 96; x++) begin
        int         ch;
        logic [7:0] row;
        ch  = int'(txt[(y / 8) * 12 + x / 8]);
        row = rom[ch * 8 + y % 8];
        exp_pix[y * 96 + x] = row[7 - x % 8] ? fgv : bgv;
      end
    end
  endtask

  // Runs one frame starting at a negedge with the DUT idle. Returns at the
  // negedge showing the frame-done pulse, or after an injected reset.
  task automatic run_frame(input string tag, input int ready_pct, input bit perturb,
                           input int abort_at, input bit chk_glyph);
    int          idx, lat, cyc, pix_err, dones;
    bit          fin, perturbed;
    logic [7:0]  bg_s, fg_s;
    logic [10:0] last_fetch, exp_last;
    logic [7:0]  first8 [8];

    bg_s     = bg_c;
    fg_s     = fg_c;
    exp_last = {txt[NCH-1], 3'b111};
    build_model(bg_s, fg_s);
    for (int i = 0; i < 8; i++) first8[i] = 8'h00;
    last_fetch = '0;

    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check({tag, "_first_addr"}, 32'(font_addr), 32'({txt[0], 3'b000}));
    check({tag, "_busy_start"}, 32'(busy), 32'd1);

    lat = 1;
    while (!valid && lat < 10) begin
      if (busy && !done) last_fetch = font_addr;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);

    idx = 0; cyc = 0; pix_err = 0; dones = 0; fin = 1'b0; perturbed = 1'b0;
    while (!fin) begin
      req = 1'b0;
      if (done) dones++;
      if (busy && !valid && !done) last_fetch = font_addr;
      if (valid && pix !== exp_pix[idx]) begin
        if (pix_err == 0)
          $display("[TB] %s first bad pixel idx=%0d (x=%0d,y=%0d) got %h want %h",
                   tag, idx, idx % 96, idx / 96, pix, exp_pix[idx]);
        pix_err++;
      end
      ready = ($urandom_range(99) < ready_pct);
      if (valid && ready) begin
        if (idx < 8) first8[idx] = pix;
        idx++;
      end
      if (perturb && !perturbed && idx >= 3000) begin
        perturbed = 1'b1;
        random_text();
        bg_c = ~bg_c;
        fg_c = 8'($urandom);
        req  = 1'b1;
      end
      if (abort_at > 0 && idx == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_rst_valid"}, 32'(valid), 32'd0);
        check({tag, "_rst_busy"},  32'(busy),  32'd0);
        check({tag, "_rst_done"},  32'(done),  32'd0);
        check({tag, "_rst_pix"},   32'(pix),   32'd0);
        check({tag, "_rst_pixerr"}, 32'(pix_err), 32'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        dones = 0;
        repeat (20) begin
          @(negedge clk);
          if (done || busy) dones++;
        end
        check({tag, "_no_done_after_abort"}, 32'(dones), 32'd0);
        $display("[TB] frame %s aborted by reset after %0d pixels", tag, idx);
        return;
      end
      if (idx == NPIX) fin = 1'b1;
      cyc++;
      if (cyc > 40000) begin
        check({tag, "_timeout"}, 32'(idx), 32'(NPIX));
        return;
      end
      @(negedge clk);
    end

    // One cycle after the final handshake.
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_valid_in_done"}, 32'(valid), 32'd0);
    check({tag, "_early_done"}, 32'(dones), 32'd0);
    check({tag, "_pixels"}, 32'(pix_err), 32'd0);
    check({tag, "_last_fetch"}, 32'(last_fetch), 32'(exp_last));
    if (chk_glyph) begin
      check({tag, "_pix0"}, 32'(first8[0]), 32'(fg_s));
      check({tag, "_pix1"}, 32'(first8[1]), 32'(bg_s));
      check({tag, "_pix6"}, 32'(first8[6]), 32'(bg_s));
      check({tag, "_pix7"}, 32'(first8[7]), 32'(fg_s));
    end
    $display("[TB] frame %s: %0d pixels, %0d cycles, %0d pixel errors", tag, idx, cyc, pix_err);
  endtask

  // Cycle after DONE: must be idle and the pulse must be gone. With
  // hold_req the request is already high in this IDLE cycle.
  task automatic idle_gap(input string tag, input bit hold_req);
    req = hold_req;
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    ready = 1'b0;
    ascii = '0;
    bg_c  = 8'h00;
    fg_c  = 8'h00;
    for (int a = 0; a < 2048; a++) rom[a] = 8'h00;

    // Reset state (request held high to show it is ignored under reset)
    req = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_pix",   32'(pix),   32'd0);
    check("reset_addr",  32'(font_addr), 32'd0);
    req   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Frame A: blank screen of spaces, ROM all zero -> every pixel background
    for (int k = 0; k < NCH; k++) txt[k] = 8'h20;
    pack_text();
    bg_c = 8'h00;
    fg_c = 8'hFF;
    run_frame("A", 100, 1'b0, 0, 1'b0);
    idle_gap("A", 1'b0);

    // Frame B: random font, 'A' at top-left with row 0 = 0x81, 'Z' at
    // bottom-right, random ready pattern
    for (int a = 0; a < 2048; a++) rom[a] = 8'($urandom);
    rom[11'h208] = 8'h81;
    random_text();
    txt[0]     = 8'h41;
    txt[NCH-1] = 8'h5A;
    pack_text();
    bg_c = 8'($urandom);
    fg_c = ~bg_c;
    run_frame("B", 50, 1'b0, 0, 1'b1);
    idle_gap("B", 1'b0);

    // Frame C: inputs changed and request pulsed mid-frame; the request is
    // then held through DONE into the following IDLE cycle
    random_text();
    bg_c = 8'($urandom);
    fg_c = 8'($urandom);
    run_frame("C", 70, 1'b1, 0, 1'b0);
    idle_gap("C", 1'b1);

    // Frame D: back-to-back start, then reset during STREAM
    random_text();
    run_frame("D", 80, 1'b0, 1500, 1'b0);

    // Frame E: full frame after the abort must start again at (0,0)
    random_text();
    bg_c = 8'($urandom);
    fg_c = 8'($urandom);
    run_frame("E", 100, 1'b0, 0, 1'b0);
    idle_gap("E", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_text_render.md
OLED_TEXT_RENDER -- requirements
Module: oled_text_render

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_COL, 96, OLED pixel columns
  NUM_ROW, 64, OLED pixel rows
  ASCII_COL_SIZE, 8, glyph width in pixels
  ASCII_ROW_SIZE, 8, glyph height in pixels
  N_COLOR_BITS, 8, pixel colour width
  Derived: NUM_ASCII_COL = NUM_COL/ASCII_COL_SIZE (12); NUM_ASCII_ROW = NUM_ROW/ASCII_ROW_SIZE (8).
REQ-002 Ports (name, direction, width, meaning), one per line:
  i_clk  in  1  single clock; all logic on its rising edge
  i_rst_n  in  1  synchronous, active-low reset
  i_frame_req  in  1  start-of-frame request
  i_ASCII  in  NUM_ASCII_COL*NUM_ASCII_ROW*8  screen text; char k (row-major from top-left) at bits [8*(96-k)-1 -: 8]
  i_BACKGROUND_COLOR  in  N_COLOR_BITS  colour for glyph bit 0
  i_TEXT_COLOR  in  N_COLOR_BITS  colour for glyph bit 1
  o_font_addr  out  11  {char[7:0], glyph_row[2:0]} to external font ROM
  i_font_data  in  8  glyph row, valid exactly 1 cycle after o_font_addr; bit 7 = leftmost pixel
  o_pix_data  out  N_COLOR_BITS  pixel colour to OLED driver
  o_pix_valid  out  1  o_pix_data valid
  i_pix_ready  in  1  driver accepts pixel when o_pix_valid && i_pix_ready
  o_busy  out  1  frame in progress
  o_frame_done  out  1  one-cycle pulse at frame end

Function
REQ-003 FSM states: IDLE, FETCH, LOAD, STREAM, DONE.
REQ-004 IDLE: when i_frame_req = 1, the block shall snapshot i_ASCII and both colours into internal registers, zero x/y counters, and enter FETCH; o_busy = 1 from the following cycle until IDLE is re-entered.
REQ-005 FETCH: the block shall drive o_font_addr = {char at (x/8, y/8), y%8} for one cycle, then enter LOAD.
REQ-006 LOAD: the block shall capture i_font_data into an 8-bit glyph shift register, then enter STREAM; the first o_pix_valid therefore occurs 3 cycles after i_frame_req is sampled.
REQ-007 STREAM: o_pix_valid = 1; o_pix_data = snapshot text colour when the current glyph MSB = 1, else snapshot background colour.
REQ-008 A handshake (o_pix_valid && i_pix_ready) shall shift the glyph register and increment x; without a handshake, o_pix_data and all counters shall hold unchanged.
REQ-009 After the 8th pixel of a glyph row is accepted: if x wraps 95->0, y shall increment; the FSM shall enter FETCH, or DONE if pixel (95,63) was just accepted.
REQ-010 Pixel order shall be raster row-major, x 0..95 within y 0..63; exactly 6144 handshakes per frame.
REQ-011 DONE: o_frame_done = 1 for exactly one cycle, o_pix_valid = 0; next state IDLE.
REQ-012 i_frame_req outside IDLE shall be ignored; i_frame_req in the IDLE cycle following DONE shall start a new frame.
REQ-013 Changes to i_ASCII or colour inputs after the snapshot shall not affect the current frame.
REQ-014 Character codes shall pass to o_font_addr unmodified, with no filtering of non-printable codes.
REQ-015 o_pix_valid shall be 0 in IDLE, FETCH, LOAD and DONE.

Reset
REQ-016 While i_rst_n = 0 at a clock edge: state = IDLE; o_pix_valid, o_busy and o_frame_done = 0; o_pix_data = 0; o_font_addr = 0; counters and snapshot cleared.
REQ-017 Reset mid-frame shall abort the frame with no o_frame_done; the next request shall restart at pixel (0,0).

Structure
REQ-018 Shared package oled_pkg shall hold the geometry constants, N_COLOR_BITS, the font-address width and the FSM state enum.
REQ-019 The glyph shift register (load, shift-on-handshake, MSB out) shall be one sub-module, oled_glyph_shift; the font ROM shall remain outside this block.

Verification
REQ-020 All chars 0x20, BG 0x00, TEXT 0xFF, ROM model returns 0x00 -> 6144 pixels all 0x00, one o_frame_done pulse one cycle after the last handshake.
REQ-021 Char 0 = 0x41, ROM returns 0x81 for address 0x208 -> first o_font_addr = 0x208; pixels (0,0) and (7,0) = TEXT, pixels (1..6,0) = BG.
REQ-022 Char 95 = 0x5A -> final fetch o_font_addr = {0x5A, 3'b111} = 0x2D7.
REQ-023 Random i_pix_ready pattern -> o_pix_data stable during every stall; pixel stream identical to the ready = 1 run.
REQ-024 i_ASCII, colours changed and i_frame_req pulsed mid-frame -> current frame unchanged; no restart.
REQ-025 i_rst_n low during STREAM -> next cycle o_pix_valid = 0, o_busy = 0, no o_frame_done; new request renders from (0,0).
